// File: rtl/accum_pkg.sv
// Shared state encoding and datapath width for the stream accumulator.
package accum_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage : accum_pkg

// File: rtl/sixteen_bit_carry_select_adder.sv
// 16-bit carry-select adder: 4-bit blocks precompute both carry-in cases and
// the incoming block carry picks the result.
module sixteen_bit_carry_select_adder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        C
);

  localparam int unsigned BLK_W  = 4;
  localparam int unsigned BLK_W1 = BLK_W + 1;
  localparam int unsigned N_BLK  = 16 / BLK_W;

  logic [N_BLK:0] carry;

  assign carry[0] = Cin;

  for (genvar g = 0; g < N_BLK; g++) begin : g_blk
    logic [BLK_W:0] sum0;
    logic [BLK_W:0] sum1;

    assign sum0 = {1'b0, A[g*BLK_W +: BLK_W]} + {1'b0, B[g*BLK_W +: BLK_W]};
    assign sum1 = {1'b0, A[g*BLK_W +: BLK_W]} + {1'b0, B[g*BLK_W +: BLK_W]} + BLK_W1'(1);

    assign S[g*BLK_W +: BLK_W] = carry[g] ? sum1[BLK_W-1:0] : sum0[BLK_W-1:0];
    assign carry[g+1]          = carry[g] ? sum1[BLK_W]     : sum0[BLK_W];
  end

  assign C = carry[N_BLK];

endmodule : sixteen_bit_carry_select_adder

// File: rtl/sixteen_bit_accumulator.sv
// Packet accumulator: sums LEN words (0 = 2^COUNT_W) from a valid/ready stream
// and holds the modulo-2^16 sum plus adder carry-out count until taken.
module sixteen_bit_accumulator
  import accum_pkg::*;
#(
  parameter int unsigned COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               START,
  input  logic [COUNT_W-1:0] LEN,
  input  logic               IN_VALID,
  input  logic [DATA_W-1:0]  IN_DATA,
  output logic               IN_READY,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [DATA_W-1:0]  SUM,
  output logic [COUNT_W-1:0] CARRY_CNT,
  output logic               BUSY
);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  acc, acc_nxt;
  logic [COUNT_W-1:0] carry_cnt, carry_cnt_nxt;
  logic [COUNT_W-1:0] remaining, remaining_nxt;
  logic [DATA_W-1:0]  add_s;
  logic               add_c;

  sixteen_bit_carry_select_adder u_adder (
    .A   (acc),
    .B   (IN_DATA),
    .Cin (1'b0),
    .S   (add_s),
    .C   (add_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      carry_cnt <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      carry_cnt <= carry_cnt_nxt;
      remaining <= remaining_nxt;
    end
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    carry_cnt_nxt = carry_cnt;
    remaining_nxt = remaining;
    IN_READY      = 1'b0;
    OUT_VALID     = 1'b0;
    BUSY          = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (START) begin
          acc_nxt       = '0;
          carry_cnt_nxt = '0;
          remaining_nxt = LEN;
          state_nxt     = ACCUM;
        end
      end
      ACCUM: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          acc_nxt       = add_s;
          carry_cnt_nxt = carry_cnt + COUNT_W'(add_c);
          // LEN=0 wraps to all-ones here, giving a full 2^COUNT_W packet.
          remaining_nxt = remaining - COUNT_W'(1);
          if (remaining == COUNT_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign SUM       = acc;
  assign CARRY_CNT = carry_cnt;

endmodule : sixteen_bit_accumulator

// File: tb/tb_sixteen_bit_accumulator.sv
// Scoreboard bench for sixteen_bit_accumulator: stimulus pushes expected
// results, a negedge monitor pops and compares when OUT_VALID rises.
module tb_sixteen_bit_accumulator;

  localparam int unsigned COUNT_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               START;
  logic [COUNT_W-1:0] LEN;
  logic               IN_VALID;
  logic [15:0]        IN_DATA;
  logic               IN_READY;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [15:0]        SUM;
  logic [COUNT_W-1:0] CARRY_CNT;
  logic               BUSY;

  sixteen_bit_accumulator #(.COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .START     (START),
    .LEN       (LEN),
    .IN_VALID  (IN_VALID),
    .IN_DATA   (IN_DATA),
    .IN_READY  (IN_READY),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .SUM       (SUM),
    .CARRY_CNT (CARRY_CNT),
    .BUSY      (BUSY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]        sum;
    logic [COUNT_W-1:0] cnt;
    int                 words;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] words_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cycle  = 0;

  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: counts transfers, checks result, latency and stability in DONE.
  int                 xfers     = 0;
  int                 last_xfer = 0;
  logic               prev_valid = 1'b0;
  logic [15:0]        held_sum;
  logic [COUNT_W-1:0] held_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      xfers      = 0;
      prev_valid = 1'b0;
    end else begin
      if (IN_VALID && IN_READY) begin
        xfers++;
        last_xfer = cycle;
      end
      if (OUT_VALID) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            chk("sum", 32'(SUM), 32'(e.sum));
            chk("carry_cnt", 32'(CARRY_CNT), 32'(e.cnt));
            chk("word_count", 32'(xfers), 32'(e.words));
            chk("out_latency", 32'(cycle), 32'(last_xfer + 1));
          end
          held_sum = SUM;
          held_cnt = CARRY_CNT;
          xfers    = 0;
        end else begin
          chk("sum_stable", 32'(SUM), 32'(held_sum));
          chk("cnt_stable", 32'(CARRY_CNT), 32'(held_cnt));
        end
        prev_valid = !OUT_READY;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(IN_READY), 32'(0));
    chk({tag, "_out_valid"}, 32'(OUT_VALID), 32'(0));
    chk({tag, "_busy"}, 32'(BUSY), 32'(0));
    chk({tag, "_sum"}, 32'(SUM), 32'(0));
    chk({tag, "_carry_cnt"}, 32'(CARRY_CNT), 32'(0));
  endtask

  task automatic start_pkt(input logic [COUNT_W-1:0] len);
    START = 1'b1;
    LEN   = len;
    @(posedge clk); #1;
    START = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    IN_VALID = 1'b1;
    IN_DATA  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (IN_READY) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 50) begin
        chk("in_ready_wait", 32'(IN_READY), 32'(1));
        break;
      end
    end
    IN_VALID = 1'b0;
    IN_DATA  = 16'h0;
  endtask

  task automatic get_result(input int hold, input bit start_in_done);
    int n;
    n = 0;
    while (!OUT_VALID && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_wait", 32'(OUT_VALID), 32'(1));
    START = start_in_done;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    OUT_READY = 1'b1;
    @(posedge clk); #1;
    OUT_READY = 1'b0;
    START     = 1'b0;
    chk("idle_after_done", 32'(BUSY), 32'(0));
  endtask

  // Words come from words_q; a START pulse can be injected after the first word.
  task automatic run_pkt(input logic [COUNT_W-1:0] len, input int max_gap, input int hold,
                         input bit poke_start, input logic [15:0] esum,
                         input logic [COUNT_W-1:0] ecnt);
    exp_t x;
    x.sum   = esum;
    x.cnt   = ecnt;
    x.words = words_q.size();
    exp_q.push_back(x);
    start_pkt(len);
    foreach (words_q[i]) begin
      send_word(words_q[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
      if (poke_start && i == 0) begin
        START = 1'b1;
        LEN   = COUNT_W'(1);
        @(posedge clk); #1;
        START = 1'b0;
      end
    end
    get_result(hold, poke_start);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    START     = 1'b0;
    LEN       = '0;
    IN_VALID  = 1'b0;
    IN_DATA   = 16'h0;
    OUT_READY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-packet discards everything immediately.
    start_pkt(COUNT_W'(3));
    send_word(16'h1234, 0);
    chk("mid_pkt_busy", 32'(BUSY), 32'(1));
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    words_q = '{16'h0005};
    run_pkt(COUNT_W'(1), 0, 0, 1'b0, 16'h0005, COUNT_W'(0));

    words_q = '{16'h0001, 16'h0002, 16'h0003};
    run_pkt(COUNT_W'(3), 0, 0, 1'b0, 16'h0006, COUNT_W'(0));

    words_q = '{16'hFFFF, 16'h0002};
    run_pkt(COUNT_W'(2), 0, 0, 1'b0, 16'h0001, COUNT_W'(1));

    words_q = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    run_pkt(COUNT_W'(4), 0, 1, 1'b0, 16'h0000, COUNT_W'(2));

    words_q.delete();
    for (int i = 0; i < 16; i++) words_q.push_back(16'hFFFF);
    run_pkt(COUNT_W'(0), 0, 0, 1'b0, 16'hFFF0, COUNT_W'(15));

    // Random input stalls, START pokes in ACCUM and DONE, 5-cycle output hold.
    words_q = '{16'h1111, 16'h2222, 16'h0F0F, 16'hF000, 16'h0123};
    run_pkt(COUNT_W'(5), 3, 5, 1'b1, 16'h3365, COUNT_W'(1));

    words_q = '{16'h7FFF, 16'h0001};
    run_pkt(COUNT_W'(2), 2, 2, 1'b0, 16'h8000, COUNT_W'(0));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    chk("final_idle", 32'(BUSY), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sixteen_bit_accumulator

// File: doc/sixteen_bit_accumulator.md
# sixteen_bit_accumulator

Sequential accumulator that consumes a stream of 16-bit words over a valid/ready handshake and sums them into a 16-bit register. It drives the A/B/Cin operands of one `sixteen_bit_carry_select_adder` instance and consumes its S/C outputs. After a programmed number of words it presents the modulo-2^16 sum and the count of adder carry-outs. It sits between the operand source (switches or an upstream producer) and the display/result logic.

## Interface
- COUNT_W, default 4: width of the word-count and carry-count fields. Maximum packet length is 2^COUNT_W words.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- START  input  1  starts a packet; sampled only in IDLE.
- LEN  input  COUNT_W  words in packet, sampled with START; 0 means 2^COUNT_W.
- IN_VALID  input  1  IN_DATA holds a word.
- IN_DATA  input  16  operand word.
- IN_READY  output  1  block accepts IN_DATA this cycle.
- OUT_VALID  output  1  SUM/CARRY_CNT are final.
- OUT_READY  input  1  consumer takes the result.
- SUM  output  16  accumulated sum, modulo 2^16.
- CARRY_CNT  output  COUNT_W  number of accepted words whose add produced C=1.
- BUSY  output  1  state is not IDLE.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: IN_READY=0, OUT_VALID=0. START=1 clears acc and carry count, loads remaining=LEN, and goes to ACCUM.
- ACCUM: IN_READY=1. Adder inputs are A=acc, B=IN_DATA, Cin=0.
  - A transfer happens when IN_VALID&&IN_READY. On a transfer: acc<=S, CARRY_CNT<=CARRY_CNT+C, remaining<=remaining-1 (mod 2^COUNT_W).
  - If the transfer takes the last word (remaining==1), go to DONE.
  - When IN_VALID=0, the block holds all state. There is no timeout.
- DONE: OUT_VALID=1, IN_READY=0. SUM and CARRY_CNT are stable. OUT_VALID&&OUT_READY returns the block to IDLE.
- START while BUSY is ignored. START and OUT_READY in the same DONE cycle: the block returns to IDLE only, and the START is not captured.
- Width rules:
  - SUM wraps modulo 2^16.
  - The first add cannot carry because acc=0. An N-word packet therefore yields at most N-1 carries, which is at most 2^COUNT_W-1. CARRY_CNT never overflows.
- LEN=0: remaining loads 0 and decrements to all-ones on the first word. The packet completes after exactly 2^COUNT_W words.
- Reset (async, any state, including mid-packet): state=IDLE, acc=0, CARRY_CNT=0, remaining=0. Outputs go to IN_READY=0, OUT_VALID=0, BUSY=0, SUM=0, CARRY_CNT=0. Any partial packet is discarded.
- SUM and CARRY_CNT are register outputs that always show current acc and count. They are meaningful only while OUT_VALID=1.

## Timing
- IN_READY, OUT_VALID and BUSY decode combinationally from the state register only. There is no combinational path from IN_VALID or OUT_READY to these outputs.
- START accepted at edge k: ACCUM and IN_READY=1 from cycle k+1.
- Word transfer at edge k: SUM updated in cycle k+1. With back-to-back IN_VALID, one word is accepted per cycle.
- Last word accepted at edge k: OUT_VALID=1 in cycle k+1 with the final SUM.
- Minimum packet latency, from START to OUT_VALID: N+1 cycles for N words.
- OUT_VALID&&OUT_READY at edge k: IDLE in cycle k+1. The earliest next START is sampled at edge k+1.
- The adder path (acc to S to acc) is single-cycle combinational and must meet the clk period.

## Structure
- Shared package `accum_pkg`:
  - state encoding constants IDLE=2'b00, ACCUM=2'b01, DONE=2'b10;
  - DATA_W=16.
- One sub-module: the existing `sixteen_bit_carry_select_adder`, instantiated once with Cin tied to 0.
- The FSM, counters and registers live in this module.

## Test plan
- Reset mid-packet: LEN=3, accept 1 word, assert rst_n=0 -> all outputs 0 and IDLE immediately. A following packet with LEN=1 and data 0x0005 gives SUM=0x0005.
- Basic sum: LEN=3, words 0x0001, 0x0002, 0x0003 back-to-back -> OUT_VALID one cycle after the third word, SUM=0x0006, CARRY_CNT=0.
- Carry/wrap: LEN=2, words 0xFFFF, 0x0002 -> SUM=0x0001, CARRY_CNT=1. LEN=4 of 0x8000 each -> SUM=0x0000, CARRY_CNT=2.
- Full length: LEN=0 with COUNT_W=4, 16 words of 0xFFFF -> accepts exactly 16 words, SUM=0xFFF0, CARRY_CNT=15.
- Handshake stalls: toggle IN_VALID randomly and hold OUT_READY=0 for 5 cycles -> no word lost or duplicated, and SUM stays stable while OUT_VALID=1. Asserting START during ACCUM/DONE is ignored.
